// File: rtl/reg_forward_unit.sv
// rtl/reg_forward_unit.sv - operand forwarding from a write-back history buffer
//
// Resolves each read port to the youngest in-flight write of the same
// register, falling back to the register-file value. The read path is
// purely combinational; only the history buffer and the pending count
// are registered.
//
// Ports:
//   in_Clock          rising-edge clock
//   in_Reset          asynchronous active-low reset
//   in_WriteValid     write-back presented this cycle
//   in_WriteAddr      write-back destination register
//   in_WriteData      write-back data
//   in_Stall          hold the history buffer
//   in_Flush          invalidate every buffered write
//   in_ReadAddr       packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   in_RegFileData    packed register-file values, port i at [i*WIDTH +: WIDTH]
//   out_ReadData      packed forwarded operands
//   out_ForwardHit    bit i set when port i took forwarded data
//   out_PendingCount  number of valid buffered entries (registered)

module reg_forward_unit #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_READ = 3,
  parameter int DEPTH    = 2,
  parameter int PC_ADDR  = 15
) (
  input  logic                             in_Clock,
  input  logic                             in_Reset,
  input  logic                             in_WriteValid,
  input  logic [ADDR_W-1:0]                in_WriteAddr,
  input  logic [WIDTH-1:0]                 in_WriteData,
  input  logic                             in_Stall,
  input  logic                             in_Flush,
  input  logic [NUM_READ*ADDR_W-1:0]       in_ReadAddr,
  input  logic [NUM_READ*WIDTH-1:0]        in_RegFileData,
  output logic [NUM_READ*WIDTH-1:0]        out_ReadData,
  output logic [NUM_READ-1:0]              out_ForwardHit,
  output logic [$clog2(DEPTH+1)-1:0]       out_PendingCount
);

  localparam int                CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_ADDR);

  // History buffer; entry 0 is the youngest write-back.
  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [WIDTH-1:0]  data_q  [DEPTH];
  logic [WIDTH-1:0]  data_d  [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  // Next-state: flush beats stall, stall beats shift. A write arriving in a
  // flush or stall cycle is only visible through the same-cycle bypass.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      addr_d[k]  = addr_q[k];
      data_d[k]  = data_q[k];
    end

    if (in_Flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = 1'b0;
      end
    end else if (!in_Stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        valid_d[k] = valid_q[k-1];
        addr_d[k]  = addr_q[k-1];
        data_d[k]  = data_q[k-1];
      end
      // An idle cycle shifts in an invalid entry so old writes still age out.
      valid_d[0] = in_WriteValid;
      addr_d[0]  = in_WriteAddr;
      data_d[0]  = in_WriteData;
    end

    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_d[k]) begin
        count_d = count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge in_Clock or negedge in_Reset) begin
    if (!in_Reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        addr_q[k]  <= '0;
        data_q[k]  <= '0;
      end
      count_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        addr_q[k]  <= addr_d[k];
        data_q[k]  <= data_d[k];
      end
      count_q <= count_d;
    end
  end

  assign out_PendingCount = count_q;

  // Per-port lookup. Sources are scanned oldest first so that each younger
  // match overwrites the previous one; the same-cycle bypass goes last and
  // therefore wins. The PC is never forwarded.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_port
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_hit;

    assign rd_addr = in_ReadAddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_data = in_RegFileData[i*WIDTH +: WIDTH];
      rd_hit  = 1'b0;
      if (rd_addr != PC_A) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (valid_q[k] && (addr_q[k] == rd_addr)) begin
            rd_data = data_q[k];
            rd_hit  = 1'b1;
          end
        end
        if (in_WriteValid && (in_WriteAddr == rd_addr)) begin
          rd_data = in_WriteData;
          rd_hit  = 1'b1;
        end
      end
    end

    assign out_ReadData[i*WIDTH +: WIDTH] = rd_data;
    assign out_ForwardHit[i]              = rd_hit;
  end

endmodule

// File: tb/tb_reg_forward_unit.sv
// tb/tb_reg_forward_unit.sv - directed and random checks of reg_forward_unit

module tb_reg_forward_unit;

  localparam int W  = 32;
  localparam int AW = 4;
  localparam int NR = 3;
  localparam int D  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wv;
  logic [AW-1:0]    wa;
  logic [W-1:0]     wd;
  logic             stall;
  logic             flush;
  logic [NR*AW-1:0] ra;
  logic [NR*W-1:0]  rf;
  logic [NR*W-1:0]  rdata;
  logic [NR-1:0]    hit;
  logic [1:0]       pend;

  always #5 clk = ~clk;

  reg_forward_unit #(
    .WIDTH(W), .ADDR_W(AW), .NUM_READ(NR), .DEPTH(D), .PC_ADDR(15)
  ) dut (
    .in_Clock         (clk),
    .in_Reset         (rst_n),
    .in_WriteValid    (wv),
    .in_WriteAddr     (wa),
    .in_WriteData     (wd),
    .in_Stall         (stall),
    .in_Flush         (flush),
    .in_ReadAddr      (ra),
    .in_RegFileData   (rf),
    .out_ReadData     (rdata),
    .out_ForwardHit   (hit),
    .out_PendingCount (pend)
  );

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } ent_t;

  ent_t hist[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    hist.delete();
    for (int k = 0; k < D; k++) hist.push_back('{1'b0, '0, '0});
  endfunction

  // Youngest pending write first: bypass, then history in age order.
  function automatic logic [W:0] model_read(input int p);
    logic [AW-1:0] a;
    logic [W-1:0]  r;
    a = ra[p*AW +: AW];
    r = rf[p*W +: W];
    if (a == 4'd15) return {1'b0, r};
    if (wv && wa == a) return {1'b1, wd};
    foreach (hist[k]) if (hist[k].v && hist[k].a == a) return {1'b1, hist[k].d};
    return {1'b0, r};
  endfunction

  function automatic int model_count();
    int n = 0;
    foreach (hist[k]) if (hist[k].v) n++;
    return n;
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_clear();
    end else if (flush) begin
      foreach (hist[k]) hist[k].v = 1'b0;
    end else if (!stall) begin
      hist.push_front('{wv, wa, wd});
      void'(hist.pop_back());
    end
  endfunction

  task automatic check_all(input string tag);
    logic [W:0] e;
    for (int p = 0; p < NR; p++) begin
      e = model_read(p);
      chk($sformatf("%s_data%0d", tag, p), rdata[p*W +: W], e[W-1:0]);
      chk($sformatf("%s_hit%0d", tag, p), hit[p], e[W]);
    end
    chk($sformatf("%s_count", tag), pend, model_count());
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic s, input logic f, input logic [NR*AW-1:0] r,
                       input logic [NR*W-1:0] rfv, input string tag);
    wv = v; wa = a; wd = d; stall = s; flush = f; ra = r; rf = rfv;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 4'd15;
    return AW'($urandom_range(0, 4));
  endfunction

  initial begin
    logic [NR*AW-1:0] r;
    rst_n = 1'b0;
    wv = 0; wa = '0; wd = '0; stall = 0; flush = 0; ra = '0; rf = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", pend, 2'd0);
    chk("reset_hit", hit, 3'b000);
    rst_n = 1'b1;

    // 1: write r3, bypass then entry 0
    drive(1, 4'd3, 32'hDEADBEEF, 0, 0, {3{4'd3}}, '0, "t1a");
    chk("t1_bypass_data", rdata, {3{32'hDEADBEEF}});
    chk("t1_bypass_hit", hit, 3'b111);
    tick();
    drive(0, 4'd0, '0, 0, 0, {3{4'd3}}, '0, "t1b");
    chk("t1_e0_data", rdata, {3{32'hDEADBEEF}});
    chk("t1_e0_count", pend, 2'd1);
    tick();

    // 2: youngest wins, then ages out after DEPTH cycles
    drive(1, 4'd2, 32'h11, 0, 0, {3{4'd0}}, '0, "t2a"); tick();
    drive(1, 4'd2, 32'h22, 0, 0, {3{4'd0}}, '0, "t2b"); tick();
    drive(0, 4'd0, '0, 0, 0, {3{4'd2}}, {3{32'h5}}, "t2c");
    chk("t2_e0", rdata[W-1:0], 32'h22); tick();
    drive(0, 4'd0, '0, 0, 0, {3{4'd2}}, {3{32'h5}}, "t2d");
    chk("t2_e1", rdata[W-1:0], 32'h22); tick();
    drive(0, 4'd0, '0, 0, 0, {3{4'd2}}, {3{32'h5}}, "t2e");
    chk("t2_aged_data", rdata[W-1:0], 32'h5);
    chk("t2_aged_hit", hit[0], 1'b0); tick();

    // 3: PC never forwards but is still buffered
    drive(0, 4'd0, '0, 0, 1, {3{4'd0}}, '0, "t3f"); tick();
    drive(1, 4'd15, 32'h100, 0, 0, {4'd0, 4'd0, 4'd15}, {3{32'h200}}, "t3a");
    chk("t3_pc_data", rdata[W-1:0], 32'h200);
    chk("t3_pc_hit", hit[0], 1'b0); tick();
    drive(0, 4'd0, '0, 0, 0, {4'd0, 4'd0, 4'd15}, {3{32'h200}}, "t3b");
    chk("t3_pc_count", pend, 2'd1); tick();

    // 4: stall holds, stalled write is bypass only
    drive(0, 4'd0, '0, 0, 1, {3{4'd0}}, '0, "t4f"); tick();
    drive(1, 4'd4, 32'hAA, 0, 0, {3{4'd0}}, '0, "t4w"); tick();
    drive(0, 4'd0, '0, 1, 0, {4'd0, 4'd5, 4'd4}, '0, "t4s1"); tick();
    drive(1, 4'd5, 32'h55, 1, 0, {4'd0, 4'd5, 4'd4}, '0, "t4s2");
    chk("t4_stall_bypass", rdata[W +: W], 32'h55);
    chk("t4_stall_e0", rdata[W-1:0], 32'hAA); tick();
    drive(0, 4'd0, '0, 1, 0, {4'd0, 4'd5, 4'd4}, '0, "t4s3");
    chk("t4_stall_count", pend, 2'd1); tick();
    drive(0, 4'd0, '0, 0, 0, {4'd0, 4'd5, 4'd4}, {3{32'h9}}, "t4e");
    chk("t4_r5_miss", hit[1], 1'b0);
    chk("t4_r4_held", rdata[W-1:0], 32'hAA); tick();

    // 5: flush with stall and write
    drive(1, 4'd7, 32'h77, 0, 0, {3{4'd0}}, '0, "t5w1"); tick();
    drive(1, 4'd8, 32'h88, 0, 0, {3{4'd0}}, '0, "t5w2"); tick();
    drive(1, 4'd6, 32'h66, 1, 1, {4'd8, 4'd7, 4'd6}, '0, "t5f");
    chk("t5_bypass", rdata[W-1:0], 32'h66);
    chk("t5_hits", hit, 3'b111); tick();
    drive(0, 4'd0, '0, 0, 0, {4'd8, 4'd7, 4'd6}, '0, "t5a");
    chk("t5_after_hit", hit, 3'b000);
    chk("t5_after_count", pend, 2'd0); tick();

    // 6: asynchronous reset mid-cycle
    drive(1, 4'd9, 32'h99, 0, 0, {3{4'd0}}, '0, "t6w1"); tick();
    drive(1, 4'd10, 32'hA0, 0, 0, {3{4'd0}}, '0, "t6w2"); tick();
    drive(0, 4'd0, '0, 0, 0, {4'd0, 4'd10, 4'd9}, {3{32'h1}}, "t6pre");
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("t6_async_count", pend, 2'd0);
    chk("t6_async_hit", hit, 3'b000);
    check_all("t6async");
    tick();
    #1 rst_n = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NR; p++) r[p*AW +: AW] = pick_addr();
      drive($urandom_range(0, 9) < 6, pick_addr(), $urandom,
            $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
            r, {$urandom, $urandom, $urandom}, "rnd");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
